// File: rtl/regfile_pkg.sv
// Shared definitions for the synchronous register file: default geometry
// and the clear-sequencer state encoding.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // CLEAR wipes the array one entry per cycle after reset; READY is normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks an index over every register once,
// raising busy until the whole array has been written with zero.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  // Last index of the array (DEPTH-1) is the all-ones address.
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_busy;

  // State, index and busy advance together; the index stops at the last
  // entry so it never begins a second pass.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (reset) begin
      r_state <= CLEAR;
      r_idx   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_idx == LAST_IDX) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        READY: begin
          r_state <= READY;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= CLEAR;
          r_idx   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign clr_we  = (r_state == CLEAR);
  assign clr_idx = r_idx;

endmodule : regfile_clear_seq

// File: rtl/regfile_sync.sv
// Two-read / one-write register file with registered read data, write-first
// bypass, optional hardwired-zero register 0 and a post-reset clear sweep.
module regfile_sync
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_wr_eff;
  logic [DATA_W-1:0] w_rd_next1;
  logic [DATA_W-1:0] w_rd_next2;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .busy    (w_busy),
    .clr_we  (w_clr_we),
    .clr_idx (w_clr_idx)
  );

  // A write takes effect only in READY, outside reset, and never to a hardwired r0.
  assign w_wr_eff = wr_en && !reset && !w_clr_we &&
                    !(ZERO_REG && (wr_addr == '0));

  // Next read value per port: hardwired zero, then same-cycle write bypass, then storage.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through this block can leave it unassigned and infer a latch.
    w_rd_next1 = r_rf[rd_addr1];
    w_rd_next2 = r_rf[rd_addr2];
    if (w_wr_eff && (wr_addr == rd_addr1)) w_rd_next1 = wr_data;
    if (w_wr_eff && (wr_addr == rd_addr2)) w_rd_next2 = wr_data;
    if (ZERO_REG && (rd_addr1 == '0))      w_rd_next1 = '0;
    if (ZERO_REG && (rd_addr2 == '0))      w_rd_next2 = '0;
  end

  // Storage update: the clear sweep owns the write port while it runs.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; it is zeroed by the clear sweep,
    // which keeps it mappable to RAM/flop arrays without a reset net per entry.
    if (w_clr_we) begin
      r_rf[w_clr_idx] <= '0;
    end else if (w_wr_eff) begin
      r_rf[wr_addr] <= wr_data;
    end
  end

  // Read-data registers: forced to zero during reset and while clearing.
  always_ff @(posedge clk) begin
    if (reset || w_clr_we) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else begin
      r_rd1 <= w_rd_next1;
      r_rd2 <= w_rd_next2;
    end
  end

  assign rd_data1 = r_rd1;
  assign rd_data2 = r_rd2;
  assign busy     = w_busy;

endmodule : regfile_sync

// File: tb/tb_regfile_sync.sv
// Directed self-checking bench for regfile_sync: default build, a
// ZERO_REG=0 build sharing its inputs, and a small ADDR_W=3/DATA_W=8 build.
module tb_regfile_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default and ZERO_REG=0 instances share one stimulus set.
  logic        reset;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] a_rd1, a_rd2, z_rd1, z_rd2;
  logic        a_busy, z_busy;

  // Small instance stimulus.
  logic        s_reset;
  logic [2:0]  s_rd_addr1, s_rd_addr2, s_wr_addr;
  logic        s_wr_en;
  logic [7:0]  s_wr_data;
  logic [7:0]  s_rd1, s_rd2;
  logic        s_busy;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_sync u_dut_a (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(a_rd1), .rd_data2(a_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(a_busy)
  );

  regfile_sync #(.ZERO_REG(1'b0)) u_dut_z (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(z_rd1), .rd_data2(z_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(z_busy)
  );

  regfile_sync #(.DATA_W(8), .ADDR_W(3)) u_dut_s (
    .clk(clk), .reset(s_reset), .rd_addr1(s_rd_addr1), .rd_addr2(s_rd_addr2),
    .rd_data1(s_rd1), .rd_data2(s_rd2), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy drops on the selected instance (0 = a, 1 = s),
  // also noting any nonzero read data seen while busy.
  task automatic count_busy(input int sel, output int n, output logic nz);
    n  = 0;
    nz = 1'b0;
    while (((sel == 0) ? a_busy : s_busy) && n < 200) begin
      if (sel == 0 && (a_rd1 != 0 || a_rd2 != 0)) nz = 1'b1;
      if (sel == 1 && (s_rd1 != 0 || s_rd2 != 0)) nz = 1'b1;
      tick();
      n++;
    end
  endtask

  int   n_busy;
  logic nz;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    s_reset = 1'b1; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_rd_addr1 = '0; s_rd_addr2 = '0;

    // Reset state after one reset edge.
    tick();
    check("rst_busy", {31'd0, a_busy}, 32'd1);
    check("rst_rd1", a_rd1, 32'd0);
    check("rst_rd2", a_rd2, 32'd0);

    // Release; attempted writes while busy must be ignored.
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFEF00D;
    rd_addr1 = 5'd5; rd_addr2 = 5'd5;
    count_busy(0, n_busy, nz);
    wr_en = 1'b0;
    check("clr_busy_cycles", n_busy, 32'd32);
    check("clr_rd_zero", {31'd0, nz}, 32'd0);
    check("clr_busy_z", {31'd0, z_busy}, 32'd0);

    // Every address reads zero after the sweep.
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      tick();
      check($sformatf("zero_p1_%0d", i), a_rd1, 32'd0);
      check($sformatf("zero_p2_%0d", 31 - i), a_rd2, 32'd0);
    end

    // Write then read from both ports.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; rd_addr1 = 5'd9; rd_addr2 = 5'd9;
    tick();
    check("rd9_p1", a_rd1, 32'hDEADBEEF);
    check("rd9_p2", a_rd2, 32'hDEADBEEF);

    // Write-first bypass, then the stored value.
    wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'h12345678; rd_addr1 = 5'd17;
    tick();
    check("bypass17", a_rd1, 32'h12345678);
    wr_en = 1'b0; rd_addr2 = 5'd17;
    tick();
    check("stored17_p1", a_rd1, 32'h12345678);
    check("stored17_p2", a_rd2, 32'h12345678);

    // Register 0: hardwired zero vs ordinary register.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr1 = 5'd9; rd_addr2 = 5'd0;
    tick();
    check("r0_bypass_zr1", a_rd2, 32'd0);
    check("r0_bypass_zr0", z_rd2, 32'hFFFFFFFF);
    check("r9_unchanged", a_rd1, 32'hDEADBEEF);
    wr_en = 1'b0; rd_addr1 = 5'd0;
    tick();
    check("r0_read_zr1", a_rd1, 32'd0);
    check("r0_read_zr0", z_rd1, 32'hFFFFFFFF);

    // Reset re-asserted at clear index 10 restarts the full sweep.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", {31'd0, a_busy}, 32'd1);
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BADBAD0;
    tick();
    reset = 1'b0;
    count_busy(0, n_busy, nz);
    wr_en = 1'b0;
    check("restart_busy_cycles", n_busy, 32'd32);
    check("restart_rd_zero", {31'd0, nz}, 32'd0);
    rd_addr1 = 5'd9; rd_addr2 = 5'd17;
    tick();
    check("restart_r9", a_rd1, 32'd0);
    check("restart_r17", a_rd2, 32'd0);
    rd_addr1 = 5'd0;
    tick();
    check("restart_r0_zr0", z_rd1, 32'd0);

    // Small geometry: ADDR_W=3, DATA_W=8.
    tick();
    s_reset = 1'b0;
    count_busy(1, n_busy, nz);
    check("s_busy_cycles", n_busy, 32'd8);
    check("s_rd_zero", {31'd0, nz}, 32'd0);
    s_wr_en = 1'b1; s_wr_addr = 3'd7; s_wr_data = 8'hA5; s_rd_addr1 = 3'd7;
    tick();
    check("s_bypass7", {24'd0, s_rd1}, 32'h000000A5);
    s_wr_en = 1'b0; s_rd_addr2 = 3'd7; s_rd_addr1 = 3'd6;
    tick();
    check("s_stored7", {24'd0, s_rd2}, 32'h000000A5);
    check("s_r6_zero", {24'd0, s_rd1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_sync

// File: doc/regfile_sync.md
REGFILE_SYNC -- requirements
Module: regfile_sync

Interface
REQ-001 Parameter DATA_W, default 32, width of each register in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rd_addr1  input  ADDR_W  read port 1 address.
REQ-007 rd_addr2  input  ADDR_W  read port 2 address.
REQ-008 rd_data1  output  DATA_W  read port 1 data, registered.
REQ-009 rd_data2  output  DATA_W  read port 2 data, registered.
REQ-010 wr_en  input  1  write strobe.
REQ-011 wr_addr  input  ADDR_W  write address.
REQ-012 wr_data  input  DATA_W  write data.
REQ-013 busy  output  1  high while the post-reset clear sequence runs; ports ignored.

Function
REQ-014 Two states: CLEAR and READY; reset forces CLEAR with clear index 0.
REQ-015 In CLEAR, each cycle writes 0 to rf[clear index] and increments the index; DEPTH cycles total.
REQ-016 On the CLEAR cycle with index DEPTH-1, next state is READY; busy deasserts in the first READY cycle.
REQ-017 In CLEAR, wr_en is ignored and rd_data1/rd_data2 are driven 0.
REQ-018 In READY, an effective write (wr_en=1 and not (ZERO_REG=1 and wr_addr=0)) stores wr_data in rf[wr_addr] at the rising edge.
REQ-019 In READY, rd_dataN at cycle N+1 equals rf[rd_addrN] as sampled at the edge ending cycle N (one-cycle latency).
REQ-020 Write-first bypass: if an effective write in cycle N targets rd_addrN, rd_dataN at cycle N+1 equals wr_data of cycle N.
REQ-021 With ZERO_REG=1, rd_addrN=0 always yields 0, including when wr_addr=0 with wr_en=1 in the same cycle.
REQ-022 Both ports may read the same address in the same cycle; both return the identical value.
REQ-023 Clear index is ADDR_W bits wide; it shall not wrap past DEPTH-1 into a second pass.
REQ-024 No combinational path from any input to rd_data1, rd_data2 or busy.

Reset
REQ-025 During reset: state=CLEAR, clear index=0, busy=1, rd_data1=0, rd_data2=0.
REQ-026 Reset asserted mid-CLEAR restarts the clear sequence at index 0; reset in READY discards any same-cycle write.
REQ-027 After reset deasserts, busy remains 1 for exactly DEPTH cycles; the register array shall read all zeros thereafter.

Structure
REQ-028 Default DATA_W, ADDR_W and the state encoding (CLEAR, READY) live in the shared processor package regfile_pkg.
REQ-029 The clear sequencer (state, index counter, busy) is one sub-module, regfile_clear_seq; storage, bypass and read registers remain in regfile_sync.

Verification
REQ-030 Reset 1 cycle then release -> busy=1 for exactly 32 cycles (defaults), rd_data=0 throughout; reading all 32 addresses afterwards returns 0.
REQ-031 Write 0xDEADBEEF to addr 9, next cycle rd_addr1=9 -> rd_data1=0xDEADBEEF one cycle later; rd_addr2=9 simultaneously -> same value.
REQ-032 Same cycle: wr_en=1, wr_addr=17, wr_data=0x12345678, rd_addr1=17 (old value 0) -> rd_data1=0x12345678 next cycle (bypass).
REQ-033 wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF, rd_addr2=0 -> rd_data2=0 next cycle and on all later reads of addr 0; repeat with ZERO_REG=0 -> 0xFFFFFFFF.
REQ-034 Reset re-asserted at clear index 10 -> index restarts at 0, busy stays 1 for full 32 cycles after release; writes with wr_en=1 during busy have no effect.
REQ-035 Parameter sweep ADDR_W=3, DATA_W=8 -> busy for 8 cycles; write 0xA5 to addr 7 reads back 0xA5.
